// File: rtl/ram_bank_if.sv
// Request/response bus of the RAM bank: valid/ready request channel plus
// an unthrottled read-response channel.
interface ram_bank_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ram_bank_ctrl.sv
// Single-port synchronous RAM bank with byte enables, registered read path
// and a post-reset clear sequencer that zeroes the array before traffic.
module ram_bank_ctrl #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int OUT_REG = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    ram_bank_if.slave  bus,
    output logic       init_done
);
    localparam int NB = DATA_W / 8;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic in_range_s;
    logic accept_s;
    logic wr_acc_s;
    logic rd_acc_s;

    // Addresses at or above DEPTH exist only when DEPTH is not a power of two.
    assign in_range_s = ({1'b0, bus.req_addr} < (ADDR_W+1)'(DEPTH));
    assign accept_s   = bus.req_valid && (state_q == RUN);
    assign wr_acc_s   = accept_s && bus.req_we && in_range_s;
    assign rd_acc_s   = accept_s && !bus.req_we;

    assign bus.req_ready = (state_q == RUN);
    assign init_done     = (state_q == RUN);

    // State and clear-pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: walk the pointer across the array, then stay in RUN.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            CLEAR: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = RUN;
                end else begin
                    state_d = CLEAR;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // Array write port: clear writes during CLEAR, byte-masked writes in RUN.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[ptr_q] <= '0;
        end else if (wr_acc_s) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.req_be[i]) begin
                    mem[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    // First read stage; data holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_acc_s;
            if (rd_acc_s) begin
                rd_data_q <= in_range_s ? mem[bus.req_addr] : '0;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              out_valid_q;
            logic [DATA_W-1:0] out_data_q;

            // Optional second read stage for the 2-cycle latency build.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_q <= 1'b0;
                    out_data_q  <= '0;
                end else begin
                    out_valid_q <= rd_valid_q;
                    if (rd_valid_q) begin
                        out_data_q <= rd_data_q;
                    end
                end
            end

            assign bus.rsp_valid = out_valid_q;
            assign bus.rsp_rdata = out_data_q;
        end else begin : g_no_out_reg
            assign bus.rsp_valid = rd_valid_q;
            assign bus.rsp_rdata = rd_data_q;
        end
    endgenerate
endmodule

// File: tb/tb_ram_bank_ctrl.sv
// Lockstep bench for two 12-word banks (OUT_REG=0 and OUT_REG=1) driven by
// identical stimulus and compared against a timestamped memory model.
module tb_ram_bank_ctrl;
    localparam int DEPTH = 12;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            drv_valid, drv_we;
    logic [AW-1:0]   drv_addr;
    logic [31:0]     drv_wdata;
    logic [3:0]      drv_be;
    logic            done0, done1;

    ram_bank_if #(.DATA_W(32), .ADDR_W(AW)) if0 ();
    ram_bank_if #(.DATA_W(32), .ADDR_W(AW)) if1 ();

    assign if0.req_valid = drv_valid;
    assign if0.req_we    = drv_we;
    assign if0.req_addr  = drv_addr;
    assign if0.req_wdata = drv_wdata;
    assign if0.req_be    = drv_be;
    assign if1.req_valid = drv_valid;
    assign if1.req_we    = drv_we;
    assign if1.req_addr  = drv_addr;
    assign if1.req_wdata = drv_wdata;
    assign if1.req_be    = drv_be;

    ram_bank_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave), .init_done(done0));
    ram_bank_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave), .init_done(done1));

    int checks = 0;
    int errors = 0;

    // Reference model: memory contents, edges since reset release, and the
    // data owed for each read keyed by the edge at which it was accepted.
    logic [31:0] mdl_mem [DEPTH];
    logic [31:0] exp_rsp [int];
    int          cyc = 0;
    int          m_edges = 0;
    logic        m_ready = 1'b0;
    logic [31:0] last0 = 32'h0;
    logic [31:0] last1 = 32'h0;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_rsp.delete();
        m_edges = 0;
        m_ready = 1'b0;
        last0   = 32'h0;
        last1   = 32'h0;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'h0;
    endtask

    task automatic check_outputs();
        logic v0, v1;
        chk("ready0", {31'h0, if0.req_ready}, {31'h0, m_ready});
        chk("ready1", {31'h0, if1.req_ready}, {31'h0, m_ready});
        chk("done0",  {31'h0, done0}, {31'h0, m_ready});
        chk("done1",  {31'h0, done1}, {31'h0, m_ready});
        v0 = exp_rsp.exists(cyc);
        v1 = exp_rsp.exists(cyc - 1);
        if (v0) last0 = exp_rsp[cyc];
        if (v1) last1 = exp_rsp[cyc - 1];
        chk("valid0", {31'h0, if0.rsp_valid}, {31'h0, v0});
        chk("rdata0", if0.rsp_rdata, last0);
        chk("valid1", {31'h0, if1.rsp_valid}, {31'h0, v1});
        chk("rdata1", if1.rsp_rdata, last1);
    endtask

    task automatic step(input logic v, input logic we, input logic [3:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
        logic acc;
        drv_valid = v;
        drv_we    = we;
        drv_addr  = a;
        drv_wdata = wd;
        drv_be    = be;
        acc = v && m_ready;
        @(posedge clk);
        cyc++;
        if (acc) begin
            if (we) begin
                if (int'(a) < DEPTH) begin
                    for (int i = 0; i < 4; i++)
                        if (be[i]) mdl_mem[a][8*i +: 8] = wd[8*i +: 8];
                end
            end else begin
                exp_rsp[cyc] = (int'(a) < DEPTH) ? mdl_mem[a] : 32'h0;
            end
        end
        m_edges++;
        if (m_edges >= DEPTH) m_ready = 1'b1;
        #1;
        check_outputs();
        drv_valid = 1'b0;
    endtask

    initial begin
        logic        pend;
        logic [31:0] pend_data;

        tbl[0]  = '{1'b1, 4'd5,  32'hDEADBEEF, 4'b1111, 32'h0};
        tbl[1]  = '{1'b0, 4'd5,  32'h0,        4'b0000, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 4'd5,  32'h11223344, 4'b0101, 32'h0};
        tbl[3]  = '{1'b0, 4'd5,  32'h0,        4'b0000, 32'hDE22BE44};
        tbl[4]  = '{1'b1, 4'd5,  32'h99999999, 4'b0000, 32'h0};
        tbl[5]  = '{1'b0, 4'd5,  32'h0,        4'b0000, 32'hDE22BE44};
        tbl[6]  = '{1'b1, 4'd1,  32'h0000000A, 4'b1111, 32'h0};
        tbl[7]  = '{1'b1, 4'd2,  32'h0000000B, 4'b1111, 32'h0};
        tbl[8]  = '{1'b1, 4'd3,  32'h0000000C, 4'b1111, 32'h0};
        tbl[9]  = '{1'b0, 4'd1,  32'h0,        4'b0000, 32'h0000000A};
        tbl[10] = '{1'b0, 4'd2,  32'h0,        4'b0000, 32'h0000000B};
        tbl[11] = '{1'b0, 4'd3,  32'h0,        4'b0000, 32'h0000000C};
        tbl[12] = '{1'b1, 4'd13, 32'hFFFFFFFF, 4'b1111, 32'h0};
        tbl[13] = '{1'b0, 4'd13, 32'h0,        4'b0000, 32'h00000000};

        drv_valid = 1'b0;
        drv_we    = 1'b0;
        drv_addr  = '0;
        drv_wdata = 32'h0;
        drv_be    = 4'h0;
        model_reset();

        #2;
        check_outputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Clear sequence: ready must rise after exactly DEPTH edges.
        for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 1'b0, 4'd0, 32'h0, 4'h0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 4'(i), 32'h0, 4'h0);
        step(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);

        pend = 1'b0;
        pend_data = 32'h0;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].be);
            if (pend) chk("tbl_rd1", if1.rsp_rdata, pend_data);
            pend = !tbl[i].we;
            pend_data = tbl[i].exp;
            if (!tbl[i].we) chk("tbl_rd0", if0.rsp_rdata, tbl[i].exp);
        end
        step(1'b1, 1'b0, 4'd11, 32'h0, 4'h0);
        if (pend) chk("tbl_rd1", if1.rsp_rdata, pend_data);
        chk("addr11_kept", if0.rsp_rdata, 32'h0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
        end

        // Mid-operation reset with a read in flight.
        step(1'b1, 1'b1, 4'd5, 32'h5A5A5A5A, 4'hF);
        step(1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
        step(1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
        chk("rst_rd5_0", if0.rsp_rdata, 32'h0);
        chk("rst_rdv_0", {31'h0, if0.rsp_valid}, 32'h1);
        step(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
        chk("rst_rd5_1", if1.rsp_rdata, 32'h0);
        chk("rst_rdv_1", {31'h0, if1.rsp_valid}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_bank_ctrl.md
# ram_bank_ctrl

Parametrised single-port synchronous RAM bank with a valid/ready request interface, per-byte write enables, a registered read path with optional extra output stage, and a hardware clear sequencer. After every reset it zeroes the whole array before accepting traffic. It replaces the flat 1K×32 combinational-read memory as the storage primitive behind the datapath and load/store units.

## Interface

Parameters:
- DATA_W, 32: word width in bits; must be a multiple of 8.
- DEPTH, 1024: number of words; need not be a power of two.
- ADDR_W, $clog2(DEPTH): address width, derived; not overridden.
- OUT_REG, 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: bank can accept a request this cycle.
- req_we, input, 1: 1 for write, 0 for read.
- req_addr, input, ADDR_W: word address.
- req_wdata, input, DATA_W: write data.
- req_be, input, DATA_W/8: byte enables; bit i covers req_wdata[8i+7:8i].
- rsp_valid, output, 1: read data valid, one-cycle pulse per read.
- rsp_rdata, output, DATA_W: read data.
- init_done, output, 1: clear sequence complete.

## Operation

- FSM states: CLEAR, RUN.
- Reset entry: rst_n low forces CLEAR and clear pointer = 0. Pipeline registers are flushed and the array is not reset directly.
- CLEAR:
  - Each cycle after rst_n deassertion, write all-zero to mem[ptr] and increment ptr.
  - After the write to DEPTH-1, go to RUN.
  - req_ready = 0 and init_done = 0 throughout.
- RUN:
  - req_ready = 1 constantly; init_done = 1.
  - A request is accepted when req_valid && req_ready.
- Write accept: for each i with req_be[i]=1, mem[req_addr] byte i <= req_wdata byte i. Bytes with be=0 are untouched. No response is generated.
- Write with req_be = 0: no change and no response. It is still accepted.
- Read accept: data is captured into the read register. rsp_valid pulses after the latency given under Timing. There is no response backpressure, and one read per cycle is sustained.
- Out-of-range address (req_addr >= DEPTH, only possible when DEPTH is not a power of two):
  - Write is dropped.
  - Read returns all-zero with a normal rsp_valid.
- rsp_rdata holds its last value when rsp_valid = 0.

## Timing

- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, init_done 0.
- The clear sequence takes exactly DEPTH cycles. With rst_n released before edge E0, the clear writes occur at edges E0 … E0+DEPTH-1. init_done and req_ready rise after edge E0+DEPTH-1.
- Read latency, for a read accepted at edge N:
  - OUT_REG=0: rsp_valid = 1 and rsp_rdata valid in the cycle after edge N (sampled at edge N+1).
  - OUT_REG=1: one cycle later (sampled at edge N+2).
- Write-then-read to the same address:
  - Write accepted at edge N, read accepted at edge N+1: the read returns the new data.
  - There is no same-cycle read/write, since the bank is single-port.
- Back-to-back reads at edges N, N+1, N+2 give rsp_valid high for three consecutive cycles, in order.
- rst_n asserted mid-operation:
  - Outputs go to reset values immediately (asynchronous); in-flight reads are discarded with no rsp_valid.
  - After release, CLEAR restarts from address 0.

## Test plan

- Reset, DEPTH=16, OUT_REG=0: release rst_n and count cycles -> init_done rises after exactly 16 edges; reads of addr 0..15 all return 0x00000000.
- Full write: write addr 5 = 0xDEADBEEF, be=4'b1111, then read addr 5 -> rsp_valid exactly 1 cycle after accept, rdata 0xDEADBEEF.
- Partial write: then write addr 5 = 0x11223344, be=4'b0101, read addr 5 -> 0xDE22BE44.
- OUT_REG=1: reads of addr 1, 2, 3 on consecutive cycles (prewritten 0xA, 0xB, 0xC) -> rsp_valid high for 3 consecutive cycles starting 2 cycles after the first accept, data 0xA, 0xB, 0xC in order.
- DEPTH=12 out of range: write addr 13 = 0xFFFFFFFF, then read addr 13 -> 0x00000000 with rsp_valid; addr 11 is unchanged.
- Mid-operation reset: issue a read, assert rst_n low in the next cycle -> no rsp_valid; req_ready goes 0 immediately; after release, clear runs DEPTH cycles; previously written addr 5 reads 0.
